div_bcd_conv: RTL and testbench
===============================

DIV_BCD_CONV -- requirements
Module: div_bcd_conv

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 ready  input  1  divider result-valid level; may stay high for many cycles.
REQ-004 QUOTN  input  8  divider quotient, unsigned; valid while ready=1.
REQ-005 REMDR  input  8  divider remainder, unsigned; valid while ready=1.
REQ-006 busy  output  1  high while a conversion is in progress (states CONV and DONE).
REQ-007 done  output  1  one-cycle pulse; q_bcd/r_bcd are valid from this cycle on.
REQ-008 q_bcd  output  12  quotient as 3 BCD digits; [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-009 r_bcd  output  12  remainder as 3 BCD digits, same digit layout as q_bcd.
REQ-010 overrun  output  1  sticky dropped-result flag; present only with DIV_BCD_OVERRUN_EN.

Function
REQ-011 A start event SHALL be an edge where ready=1 and a registered copy ready_d=0. ready_d updates every cycle in all states.
REQ-012 States SHALL be IDLE, CONV and DONE.
REQ-013 IDLE or DONE with a start event: capture QUOTN/REMDR into working registers, clear BCD accumulators and cnt, go to CONV.
REQ-014 DONE without a start event: go to IDLE.
REQ-015 CONV: each edge performs one double-dabble step on both operands in parallel.
  - Every accumulator digit >=5 gets +3.
  - Then shift left one bit, taking in the working register MSB.
  - Then increment cnt.
REQ-016 CONV conversion edges:
  - On the 8th step edge, latch final BCD values into q_bcd/r_bcd, set done=1 and go to DONE.
  - The 8th step edge is the 8th edge after the capture edge.
REQ-017 done SHALL be high for exactly one cycle per accepted start event.
REQ-018 Latency: done is high in the cycle following the 8th edge after the capture edge.
REQ-019 q_bcd/r_bcd SHALL change only on the done-setting edge and hold their value otherwise.
REQ-020 Each BCD digit output SHALL lie in 0..9; q_bcd hundreds digit SHALL be <=2.
REQ-021 Start events in CONV SHALL be ignored: no restart and no change to the conversion in progress.
REQ-022 ready held high across a finished conversion SHALL NOT start another; a new start needs ready low for at least one sampled cycle.
REQ-023 A start event in DONE SHALL give back-to-back operation: the new conversion's capture edge is the edge leaving DONE.

Reset
REQ-024 With rst=1 at an edge, the block SHALL set:
  - state=IDLE, cnt=0, ready_d=0.
  - done=0, busy=0.
  - q_bcd=12'h000, r_bcd=12'h000.
  - overrun=0 when DIV_BCD_OVERRUN_EN is defined.
REQ-025 Reset SHALL take priority over all other activity, including mid-CONV.
REQ-026 A conversion cut by reset SHALL produce no done pulse.
REQ-027 ready=1 on the first edge after rst deasserts SHALL count as a start event, because ready_d=0.

Configuration
REQ-028 Macro DIV_BCD_OVERRUN_EN:
  - Defined: port overrun exists; it is set to 1 by a start event ignored in CONV (REQ-021) and cleared only by rst.
  - Not defined: port overrun and its logic are absent; ignored start events leave no trace.
  - All other behaviour is identical either way.

Verification
REQ-029 QUOTN=255, REMDR=0, ready rises after reset -> done one cycle after the 8th edge past capture; q_bcd=12'h255, r_bcd=12'h000; busy high in CONV and DONE only.
REQ-030 QUOTN=7, REMDR=3, then QUOTN=100, REMDR=99 (ready low between) -> q_bcd=12'h007, r_bcd=12'h003, then q_bcd=12'h100, r_bcd=12'h099; exactly two done pulses.
REQ-031 ready held high 30 cycles with QUOTN=42 -> exactly one done pulse; q_bcd=12'h042 held afterwards.
REQ-032 rst asserted on the 4th conversion edge of QUOTN=199 -> no done; q_bcd=12'h000; busy=0 next cycle; a new QUOTN=199 start then yields q_bcd=12'h199.
REQ-033 With DIV_BCD_OVERRUN_EN: ready pulses low-high during CONV -> result of first operands unchanged, one done pulse; overrun=1 and stays 1 until rst. Without macro: same q_bcd/done behaviour.
REQ-034 ready rises again in the DONE cycle with QUOTN=8 -> second conversion starts with no IDLE gap; q_bcd=12'h008 one cycle after the 8th edge past that capture edge.

Source files
------------

// File: rtl/div_bcd_conv.sv
// Converts an 8-bit divider quotient/remainder pair to 3-digit BCD using double-dabble.
// One step per clock: capture, 8 steps, then a one-cycle done. Optional macro: DIV_BCD_OVERRUN_EN.
module div_bcd_conv (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  input  logic [7:0]  QUOTN,
  input  logic [7:0]  REMDR,
`ifdef DIV_BCD_OVERRUN_EN
  output logic        overrun,
`endif
  output logic        busy,
  output logic        done,
  output logic [11:0] q_bcd,
  output logic [11:0] r_bcd
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  q_work_q, q_work_d, r_work_q, r_work_d;
  logic [11:0] q_acc_q, q_acc_d, r_acc_q, r_acc_d;
  logic [11:0] q_bcd_q, q_bcd_d, r_bcd_q, r_bcd_d;
  logic        done_q, done_d;
  logic        ready_d_q;
  logic        start;
  logic [11:0] q_step, r_step;
`ifdef DIV_BCD_OVERRUN_EN
  logic        overrun_q, overrun_d;
`endif

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
  function automatic logic [11:0] dd_step(input logic [11:0] acc, input logic msb);
    logic [11:0] adj;
    adj = acc;
    for (int i = 0; i < 3; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    adj = {adj[10:0], msb};
    return adj;
  endfunction

  assign start  = ready & ~ready_d_q;
  assign q_step = dd_step(q_acc_q, q_work_q[7]);
  assign r_step = dd_step(r_acc_q, r_work_q[7]);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    q_work_d = q_work_q;
    r_work_d = r_work_q;
    q_acc_d  = q_acc_q;
    r_acc_d  = r_acc_q;
    q_bcd_d  = q_bcd_q;
    r_bcd_d  = r_bcd_q;
    done_d   = 1'b0;
`ifdef DIV_BCD_OVERRUN_EN
    overrun_d = overrun_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          q_work_d = QUOTN;
          r_work_d = REMDR;
          q_acc_d  = 12'h000;
          r_acc_d  = 12'h000;
          cnt_d    = 3'd0;
          state_d  = CONV;
        end else begin
          state_d  = IDLE;
        end
      end
      CONV: begin
        q_acc_d  = q_step;
        r_acc_d  = r_step;
        q_work_d = {q_work_q[6:0], 1'b0};
        r_work_d = {r_work_q[6:0], 1'b0};
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          q_bcd_d = q_step;
          r_bcd_d = r_step;
          done_d  = 1'b1;
          state_d = DONE;
        end
`ifdef DIV_BCD_OVERRUN_EN
        // A new result arriving mid-conversion is dropped; remember that it happened.
        if (start) overrun_d = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      q_work_q  <= 8'h00;
      r_work_q  <= 8'h00;
      q_acc_q   <= 12'h000;
      r_acc_q   <= 12'h000;
      q_bcd_q   <= 12'h000;
      r_bcd_q   <= 12'h000;
      done_q    <= 1'b0;
      ready_d_q <= 1'b0;
`ifdef DIV_BCD_OVERRUN_EN
      overrun_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      q_work_q  <= q_work_d;
      r_work_q  <= r_work_d;
      q_acc_q   <= q_acc_d;
      r_acc_q   <= r_acc_d;
      q_bcd_q   <= q_bcd_d;
      r_bcd_q   <= r_bcd_d;
      done_q    <= done_d;
      ready_d_q <= ready;
`ifdef DIV_BCD_OVERRUN_EN
      overrun_q <= overrun_d;
`endif
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign q_bcd = q_bcd_q;
  assign r_bcd = r_bcd_q;
`ifdef DIV_BCD_OVERRUN_EN
  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_div_bcd_conv.sv
// Self-checking bench for div_bcd_conv: vector table, random operands against an
// arithmetic BCD model, and hand-written reset/overrun/back-to-back/hold-high sequences.
module tb_div_bcd_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [7:0]  QUOTN, REMDR;
  logic        busy, done;
  logic [11:0] q_bcd, r_bcd;
`ifdef DIV_BCD_OVERRUN_EN
  logic        overrun;
`endif

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  div_bcd_conv dut (
    .clk     (clk),
    .rst     (rst),
    .ready   (ready),
    .QUOTN   (QUOTN),
    .REMDR   (REMDR),
`ifdef DIV_BCD_OVERRUN_EN
    .overrun (overrun),
`endif
    .busy    (busy),
    .done    (done),
    .q_bcd   (q_bcd),
    .r_bcd   (r_bcd)
  );

  always #5 clk = ~clk;

  // done is sampled before the edge updates it, so each high cycle counts once.
  always @(posedge clk) if (done === 1'b1) done_cnt++;

  typedef struct {
    logic [7:0]  q;
    logic [7:0]  r;
    logic [11:0] exp_q;
    logic [11:0] exp_r;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  // Waits (bounded) for done; lat is the number of negedges waited, 0 on timeout.
  task automatic wait_done(output int lat, output int busy_low);
    lat = 0;
    busy_low = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_low++;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_conv(input string name, input logic [7:0] q, input logic [7:0] r,
                          input logic [11:0] eq, input logic [11:0] er);
    int lat, bl;
    @(negedge clk);
    QUOTN = q; REMDR = r; ready = 1'b1;
    wait_done(lat, bl);
    check({name, " latency"}, lat, 9);
    check({name, " busy"}, bl, 0);
    check({name, " q_bcd"}, q_bcd, eq);
    check({name, " r_bcd"}, r_bcd, er);
    ready = 1'b0;
    @(negedge clk);
    check({name, " done pulse width"}, done, 0);
    check({name, " idle busy"}, busy, 0);
    check({name, " q_bcd held"}, q_bcd, eq);
  endtask

  initial begin
    int lat, bl, d0;
    logic [7:0] rq, rr;

    vecs[0] = '{8'd255, 8'd0,   12'h255, 12'h000};
    vecs[1] = '{8'd7,   8'd3,   12'h007, 12'h003};
    vecs[2] = '{8'd100, 8'd99,  12'h100, 12'h099};
    vecs[3] = '{8'd0,   8'd0,   12'h000, 12'h000};
    vecs[4] = '{8'd9,   8'd10,  12'h009, 12'h010};
    vecs[5] = '{8'd199, 8'd255, 12'h199, 12'h255};

    rst = 1'b1; ready = 1'b0; QUOTN = 8'h00; REMDR = 8'h00;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset q_bcd", q_bcd, 12'h000);
    check("reset r_bcd", r_bcd, 12'h000);
`ifdef DIV_BCD_OVERRUN_EN
    check("reset overrun", overrun, 0);
`endif
    rst = 1'b0;

    d0 = done_cnt;
    foreach (vecs[i]) run_conv($sformatf("vec%0d", i), vecs[i].q, vecs[i].r,
                               vecs[i].exp_q, vecs[i].exp_r);
    check("table done count", done_cnt - d0, 6);

    for (int i = 0; i < 20; i++) begin
      rq = 8'($urandom_range(0, 255));
      rr = 8'($urandom_range(0, 255));
      run_conv($sformatf("rand%0d q=%0d r=%0d", i, rq, rr), rq, rr, to_bcd(rq), to_bcd(rr));
    end

    // ready held high: a single conversion only.
    @(negedge clk);
    d0 = done_cnt;
    QUOTN = 8'd42; REMDR = 8'd0; ready = 1'b1;
    repeat (30) @(negedge clk);
    check("hold-high done count", done_cnt - d0, 1);
    check("hold-high q_bcd", q_bcd, 12'h042);
    ready = 1'b0;
    @(negedge clk);

    // Reset sampled on the 4th conversion edge.
    d0 = done_cnt;
    QUOTN = 8'd199; REMDR = 8'd0; ready = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1; ready = 1'b0;
    @(negedge clk);
    check("mid-reset busy", busy, 0);
    check("mid-reset q_bcd", q_bcd, 12'h000);
    repeat (12) @(negedge clk);
    check("mid-reset no done", done_cnt - d0, 0);
    rst = 1'b0; ready = 1'b1; QUOTN = 8'd199; REMDR = 8'd0;
    wait_done(lat, bl);
    check("post-reset latency", lat, 9);
    check("post-reset q_bcd", q_bcd, 12'h199);
    ready = 1'b0;
    @(negedge clk);

    // Start event during CONV is ignored.
    d0 = done_cnt;
    QUOTN = 8'd123; REMDR = 8'd45; ready = 1'b1;
    repeat (2) @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    ready = 1'b1; QUOTN = 8'd77; REMDR = 8'd11;
    wait_done(lat, bl);
    check("overrun latency", lat, 6);
    check("overrun q_bcd", q_bcd, 12'h123);
    check("overrun r_bcd", r_bcd, 12'h045);
    ready = 1'b0;
    repeat (15) @(negedge clk);
    check("overrun done count", done_cnt - d0, 1);
`ifdef DIV_BCD_OVERRUN_EN
    check("overrun flag set", overrun, 1);
`endif

    // Back-to-back: new start in the DONE cycle.
    QUOTN = 8'd50; REMDR = 8'd5; ready = 1'b1;
    repeat (8) @(negedge clk);
    check("b2b first not done early", done, 0);
    ready = 1'b0;
    @(negedge clk);
    check("b2b first done", done, 1);
    check("b2b first q_bcd", q_bcd, 12'h050);
    QUOTN = 8'd8; REMDR = 8'd0; ready = 1'b1;
    @(negedge clk);
    check("b2b no idle gap", busy, 1);
    check("b2b done one cycle", done, 0);
    wait_done(lat, bl);
    check("b2b second latency", lat, 8);
    check("b2b second q_bcd", q_bcd, 12'h008);
    ready = 1'b0;
    @(negedge clk);

`ifdef DIV_BCD_OVERRUN_EN
    check("overrun sticky", overrun, 1);
    rst = 1'b1;
    @(negedge clk);
    check("overrun cleared by rst", overrun, 0);
    rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
